// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths, bus layouts, load-type and CP0 op encodings for the memory stage
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 202;
  localparam int MS_TO_WS_BUS_WD = 163;
  localparam int MS_TO_DS_BUS_WD = 43;
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4,
    LD_WL = 3'd5,
    LD_WR = 3'd6
  } ld_type_e;
  localparam logic [1:0] CP0_NONE = 2'b00;
  localparam logic [1:0] CP0_MFC0 = 2'b01;
  localparam logic [1:0] CP0_MTC0 = 2'b10;
  localparam logic [1:0] CP0_ERET = 2'b11;
  typedef struct packed {
    logic [2:0]  tlb_type;
    logic        at_delay_slot;
    logic [41:0] cp0_msg;
    logic [11:0] exception;
    logic [31:0] badvaddr;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;
  typedef struct packed {
    logic       mem_req;
    logic       is_load;
    ld_type_e   ld_type;
    logic [1:0] addr_lo;
    logic [31:0] rt_value;
    ms_to_ws_t  ws;
  } es_to_ms_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data extraction (LB/LBU/LH/LHU/LW/LWL/LWR)
// Ports: ld_type, addr_lo (byte offset), rdata (memory word), rt_value (old rt for LWL/LWR) -> result
module load_align import mem_stage_pkg::*; (
  input  ld_type_e    ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] result
);
  logic [31:0] sh, lwl, lwr;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh  = rdata >> {addr_lo, 3'b0};
  assign b   = sh[7:0];
  assign h   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  // LWL keeps the low 3-k bytes of rt, LWR keeps the high k bytes of rt
  assign lwl = (rdata << {~addr_lo, 3'b0}) | (rt_value & (32'h00ff_ffff >> {addr_lo, 3'b0}));
  assign lwr = sh | (rt_value & ~(32'hffff_ffff >> {addr_lo, 3'b0}));
  always_comb
    result = ld_type == LD_B  ? {{24{b[7]}}, b}  :
             ld_type == LD_BU ? {24'd0, b}       :
             ld_type == LD_H  ? {{16{h[15]}}, h} :
             ld_type == LD_HU ? {16'd0, h}       :
             ld_type == LD_WL ? lwl              :
             ld_type == LD_WR ? lwr              : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB with data-port response tracking
// Ports: clk/reset (sync, active-high); es_to_ms_valid/bus in, ms_allowin out;
//   ms_to_ws_valid/bus out, ws_allowin in; ms_to_ds_bus forwarding out; ms_to_es_ex out;
//   ws_flush in; data_sram_req/addr_ok/data_ok/rdata observed from the data port.
// Build option: MS_LOAD_FWD_EN lets a returned load result forward to ID before WB.
module mem_stage import mem_stage_pkg::*; #(
  parameter int OUTST_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_to_es_ex,
  input  logic                       ws_flush,
  input  logic                       data_sram_req,
  input  logic                       data_sram_addr_ok,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);
  es_to_ms_t          es_q, es_d;
  ms_to_ws_t          ws_out;
  logic               ms_valid_q, ms_valid_d, buf_valid_q, buf_valid_d;
  logic [31:0]        buf_data_q, buf_data_d, rdata, ld_res;
  logic [OUTST_W-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [OUTST_W:0]   outst_sum;
  logic               resp_hit, ms_ready_go, handoff, capture, fwd_blocking;
  // responses are only ours once every response owed to flushed instructions has drained
  assign resp_hit       = data_sram_data_ok && discard_q == '0;
  assign ms_ready_go    = !es_q.mem_req || buf_valid_q || resp_hit;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign handoff        = ms_to_ws_valid && ws_allowin;
  assign capture        = resp_hit && ms_valid_q && es_q.mem_req && !buf_valid_q && !(ms_ready_go && ws_allowin);
  assign rdata          = buf_valid_q ? buf_data_q : data_sram_rdata;
  // one extra bit so an overflow or underflow shows up in the MSB
  assign outst_sum      = {1'b0, outst_q} + (OUTST_W+1)'(data_sram_req && data_sram_addr_ok)
                          - (OUTST_W+1)'(data_sram_data_ok);
  always_comb begin
    ms_valid_d  = ws_flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid_q;
    es_d        = (es_to_ms_valid && ms_allowin) ? es_to_ms_t'(es_to_ms_bus) : es_q;
    buf_valid_d = (ws_flush || handoff) ? 1'b0 : capture ? 1'b1 : buf_valid_q;
    buf_data_d  = capture ? data_sram_rdata : buf_data_q;
    outst_d     = outst_sum[OUTST_W-1:0];
    // on flush every transaction still in flight belongs to a squashed instruction
    discard_d   = ws_flush ? outst_d : discard_q - OUTST_W'(data_sram_data_ok && discard_q != '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      es_q        <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      es_q        <= es_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
    end
  end
  a_outst_range: assert property (@(posedge clk) disable iff (reset) !outst_sum[OUTST_W]);
  a_discard_le:  assert property (@(posedge clk) disable iff (reset) discard_q <= outst_q);
  load_align u_align (
    .ld_type  (es_q.ld_type),
    .addr_lo  (es_q.addr_lo),
    .rdata    (rdata),
    .rt_value (es_q.rt_value),
    .result   (ld_res)
  );
  always_comb begin
    ws_out              = es_q.ws;
    ws_out.final_result = es_q.is_load ? ld_res : es_q.ws.final_result;
    ws_out.gr_we        = es_q.is_load ? 4'hF : es_q.ws.gr_we;
  end
  assign ms_to_ws_bus = ws_out;
`ifdef MS_LOAD_FWD_EN
  assign fwd_blocking = ms_valid_q && es_q.is_load && !ms_ready_go;
`else
  assign fwd_blocking = ms_valid_q && es_q.is_load;
`endif
  assign ms_to_ds_bus = {ms_valid_q && ws_out.gr_we != 4'h0, fwd_blocking, ws_out.gr_we, ws_out.dest, ws_out.final_result};
  assign ms_to_es_ex  = ms_valid_q && (|es_q.ws.exception || es_q.ws.cp0_msg[41:40] == CP0_ERET);
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with directed load/flush/buffer vectors
module tb_mem_stage import mem_stage_pkg::*;;
  logic         clk, reset, ws_allowin, ms_allowin, es_to_ms_valid, ms_to_ws_valid, ms_to_es_ex;
  logic         ws_flush, req, addr_ok, data_ok;
  logic [201:0] es_bus;
  logic [162:0] ws_bus;
  logic [42:0]  ds_bus;
  logic [31:0]  rdata, pc_n;
  logic [67:0]  q[$];
  logic [67:0]  e, a;
  int           checks, errors;
  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_bus), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ws_bus), .ms_to_ds_bus(ds_bus), .ms_to_es_ex(ms_to_es_ex), .ws_flush(ws_flush),
    .data_sram_req(req), .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [201:0] mk(input logic mr, il, input logic [2:0] lt, input logic [1:0] lo,
                                      input logic [31:0] rt, res, pc, input logic [4:0] dst,
                                      input logic [3:0] we, input logic [11:0] exc, input logic [1:0] cop);
    return {mr, il, lt, lo, rt, 3'd0, 1'b0, cop, 40'd0, exc, 32'd0, we, dst, res, pc};
  endfunction
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #3;
  endtask
  task automatic chk(input string n, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // monitor: every WB handoff must match the oldest expected response
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      checks++;
      a = {ws_bus[63:32], ws_bus[72:69], ws_bus[31:0]};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL handoff_unexpected: got result=%h we=%h pc=%h", a[67:36], a[35:32], a[31:0]);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL handoff_pc%h: got result=%h we=%h pc=%h expected result=%h we=%h pc=%h",
                   e[31:0], a[67:36], a[35:32], a[31:0], e[67:36], e[35:32], e[31:0]);
        end
      end
    end
  end
  task automatic issue_load(input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] rt,
                            input logic exp_on, input logic [31:0] ex);
    es_to_ms_valid = 1'b1;
    es_bus = mk(1'b1, 1'b1, lt, lo, rt, 32'hDEAD, pc_n, 5'd3, 4'h0, 12'd0, 2'b00);
    req = 1'b1;
    addr_ok = 1'b1;
    if (exp_on) q.push_back({ex, 4'hF, pc_n});
    pc_n += 4;
  endtask
  task automatic do_load(input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] rt, rd, ex, input int w);
    issue_load(lt, lo, rt, 1'b1, ex);
    cyc;
    es_to_ms_valid = 1'b0;
    req = 1'b0;
    addr_ok = 1'b0;
    for (int i = 0; i < w; i++) begin
      settle;
      chk("ld_wait_valid", 32'(ms_to_ws_valid), 0);
      chk("ld_wait_allowin", 32'(ms_allowin), 0);
      chk("ld_fwd_blocking", 32'(ds_bus[41]), 1);
      cyc;
    end
    data_ok = 1'b1;
    rdata = rd;
    settle;
    chk("ld_ready_same_cycle", 32'(ms_to_ws_valid), 1);
    cyc;
    data_ok = 1'b0;
  endtask
  task automatic alu(input logic [31:0] res, input logic [11:0] exc, input logic [1:0] cop, input logic ex);
    es_to_ms_valid = 1'b1;
    es_bus = mk(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, res, pc_n, 5'd7, 4'hF, exc, cop);
    q.push_back({res, 4'hF, pc_n});
    pc_n += 4;
    cyc;
    es_to_ms_valid = 1'b0;
    settle;
    chk("alu_valid", 32'(ms_to_ws_valid), 1);
    chk("alu_fwd_valid", 32'(ds_bus[42]), 1);
    chk("alu_fwd_blocking", 32'(ds_bus[41]), 0);
    chk("alu_fwd_data", ds_bus[31:0], res);
    chk("alu_ms_to_es_ex", 32'(ms_to_es_ex), 32'(ex));
    cyc;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_bus = '0;
    req = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata = '0;
    ws_flush = 1'b0;
    pc_n = 32'h0000_1000;
    repeat (2) cyc;
    settle;
    chk("rst_ms_to_ws_valid", 32'(ms_to_ws_valid), 0);
    chk("rst_ms_allowin", 32'(ms_allowin), 1);
    chk("rst_fwd_valid", 32'(ds_bus[42]), 0);
    chk("rst_ms_to_es_ex", 32'(ms_to_es_ex), 0);
    cyc;
    reset = 1'b0;
    alu(32'h0000_1234, 12'd0, 2'b00, 1'b0);
    alu(32'h0000_0055, 12'h004, 2'b00, 1'b1);
    alu(32'h0000_0066, 12'd0, 2'b11, 1'b1);
    alu(32'h0000_0077, 12'd0, 2'b01, 1'b0);
    do_load(LD_W,  2'd0, 32'h0,         32'h89AB_CDEF, 32'h89AB_CDEF, 2);
    do_load(LD_B,  2'd2, 32'h0,         32'h1280_3456, 32'hFFFF_FF80, 0);
    do_load(LD_BU, 2'd2, 32'h0,         32'h1280_3456, 32'h0000_0080, 0);
    do_load(LD_B,  2'd3, 32'h0,         32'h1280_3456, 32'h0000_0012, 0);
    do_load(LD_WL, 2'd1, 32'hAABB_CCDD, 32'h1280_3456, 32'h3456_CCDD, 0);
    do_load(LD_WL, 2'd0, 32'hAABB_CCDD, 32'h1280_3456, 32'h56BB_CCDD, 0);
    do_load(LD_WL, 2'd3, 32'hAABB_CCDD, 32'h1280_3456, 32'h1280_3456, 0);
    do_load(LD_H,  2'd2, 32'h0,         32'h1280_3456, 32'h0000_1280, 1);
    do_load(LD_H,  2'd0, 32'h0,         32'h1280_F456, 32'hFFFF_F456, 0);
    do_load(LD_HU, 2'd0, 32'h0,         32'h1280_F456, 32'h0000_F456, 0);
    do_load(LD_WR, 2'd1, 32'hAABB_CCDD, 32'h1280_3456, 32'hAA12_8034, 0);
    do_load(LD_WR, 2'd3, 32'hAABB_CCDD, 32'h1280_3456, 32'hAABB_CC12, 0);
    do_load(LD_WR, 2'd0, 32'hAABB_CCDD, 32'h1280_3456, 32'h1280_3456, 0);
    // response arrives while WB is stalled: must be buffered and handed off once
    issue_load(LD_W, 2'd0, 32'h0, 1'b1, 32'h55AA_1234);
    cyc;
    es_to_ms_valid = 1'b0;
    req = 1'b0;
    addr_ok = 1'b0;
    ws_allowin = 1'b0;
    data_ok = 1'b1;
    rdata = 32'h55AA_1234;
    settle;
    chk("buf_first_valid", 32'(ms_to_ws_valid), 1);
    cyc;
    data_ok = 1'b0;
    rdata = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk("buf_hold_valid", 32'(ms_to_ws_valid), 1);
      chk("buf_hold_data", ws_bus[63:32], 32'h55AA_1234);
      chk("buf_hold_allowin", 32'(ms_allowin), 0);
      cyc;
    end
    ws_allowin = 1'b1;
    settle;
    chk("buf_release_valid", 32'(ms_to_ws_valid), 1);
    cyc;
    settle;
    chk("buf_after_release", 32'(ms_to_ws_valid), 0);
    cyc;
    // two transactions in flight then flush: both responses must be dropped
    issue_load(LD_W, 2'd0, 32'h0, 1'b0, 32'h0);
    cyc;
    es_to_ms_valid = 1'b0;
    settle;
    chk("fl_wait_valid", 32'(ms_to_ws_valid), 0);
    cyc;
    req = 1'b0;
    addr_ok = 1'b0;
    ws_flush = 1'b1;
    settle;
    chk("fl_flush_valid", 32'(ms_to_ws_valid), 0);
    cyc;
    ws_flush = 1'b0;
    settle;
    chk("fl_allowin_after", 32'(ms_allowin), 1);
    issue_load(LD_W, 2'd0, 32'h0, 1'b1, 32'h600D_F00D);
    cyc;
    es_to_ms_valid = 1'b0;
    req = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b1;
    rdata = 32'hBAD0_0001;
    settle;
    chk("fl_drop1", 32'(ms_to_ws_valid), 0);
    cyc;
    rdata = 32'hBAD0_0002;
    settle;
    chk("fl_drop2", 32'(ms_to_ws_valid), 0);
    cyc;
    rdata = 32'h600D_F00D;
    settle;
    chk("fl_accept3", 32'(ms_to_ws_valid), 1);
    cyc;
    data_ok = 1'b0;
    // flush in the same cycle as a response with two in flight: exactly one more to drop
    issue_load(LD_W, 2'd0, 32'h0, 1'b0, 32'h0);
    cyc;
    es_to_ms_valid = 1'b0;
    settle;
    cyc;
    req = 1'b0;
    addr_ok = 1'b0;
    ws_flush = 1'b1;
    data_ok = 1'b1;
    rdata = 32'hDEAD_BEEF;
    ws_allowin = 1'b0;
    settle;
    chk("flb_pre_valid", 32'(ms_to_ws_valid), 1);
    cyc;
    ws_flush = 1'b0;
    data_ok = 1'b0;
    ws_allowin = 1'b1;
    settle;
    chk("flb_ms_cleared", 32'(ms_to_ws_valid), 0);
    chk("flb_allowin", 32'(ms_allowin), 1);
    issue_load(LD_W, 2'd0, 32'h0, 1'b1, 32'h0BAD_CAFE);
    cyc;
    es_to_ms_valid = 1'b0;
    req = 1'b0;
    addr_ok = 1'b0;
    settle;
    chk("flb_buf_cleared", 32'(ms_to_ws_valid), 0);
    cyc;
    data_ok = 1'b1;
    rdata = 32'h1111_1111;
    settle;
    chk("flb_drop1", 32'(ms_to_ws_valid), 0);
    cyc;
    rdata = 32'h0BAD_CAFE;
    settle;
    chk("flb_accept2", 32'(ms_to_ws_valid), 1);
    cyc;
    data_ok = 1'b0;
    repeat (2) cyc;
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
